add_disp_ctrl: RTL and testbench

Sequencing controller for the 4-bit adder / binary-to-decimal / 7-segment display path. It accepts an operand pair through a valid/ready handshake and drives the shared external 4-bit adder. It captures {Cout,sum}, converts it to tens/ones digits by iterative subtract-10, and holds the result. It time-multiplexes the two digits onto one digit bus with active-low anode enables for the external segment decoder.

---
 rtl/add_disp_ctrl.sv | 161 ++++++++++++++++
 tb/tb_add_disp_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_disp_ctrl.sv
// Sequencing controller for the 4-bit adder / binary-to-decimal / 7-segment path.
// Accepts an operand pair, drives the shared external adder, and captures
// {cout,sum}. It splits the result into tens/ones by repeated subtract-10 and
// scans the two digits onto one digit bus with active-low anode enables.
module add_disp_ctrl #(
  parameter int REFRESH_DIV = 4,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [3:0] add_sum,
  input  logic       add_cout,
  output logic [4:0] result,
  output logic       ovf,
  output logic       done,
  output logic [3:0] dig,
  output logic [1:0] an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CONVERT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  add_a_q, add_a_d;
  logic [3:0]  add_b_q, add_b_d;
  logic [4:0]  result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [4:0]  work_q, work_d;
  logic [1:0]  tens_q, tens_d;
  logic [1:0]  disp_tens_q, disp_tens_d;
  logic [3:0]  disp_ones_q, disp_ones_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          slot_q, slot_d;
  logic [1:0]    an_q, an_d;
  logic [3:0]    dig_q, dig_d;

  // Controller state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      add_a_q     <= '0;
      add_b_q     <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      work_q      <= '0;
      tens_q      <= '0;
      disp_tens_q <= '0;
      disp_ones_q <= '0;
    end else begin
      state_q     <= state_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      work_q      <= work_d;
      tens_q      <= tens_d;
      disp_tens_q <= disp_tens_d;
      disp_ones_q <= disp_ones_d;
    end
  end

  // Next-state logic: accept, capture adder output, then one subtract-10 per cycle.
  always_comb begin
    state_d     = state_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    work_d      = work_q;
    tens_d      = tens_q;
    disp_tens_d = disp_tens_q;
    disp_ones_d = disp_ones_q;
    in_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          add_a_d = a;
          add_b_d = b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // External adder has had a full cycle to settle on add_a/add_b.
        result_d = {add_cout, add_sum};
        ovf_d    = add_cout;
        work_d   = {add_cout, add_sum};
        tens_d   = '0;
        state_d  = CONVERT;
      end
      CONVERT: begin
        if (work_q >= 5'd10) begin
          work_d = work_q - 5'd10;
          tens_d = tens_q + 2'd1;
        end else begin
          // Display registers update only with a complete result.
          disp_tens_d = tens_q;
          disp_ones_d = work_q[3:0];
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan counter, slot and registered digit/anode outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      slot_q <= 1'b0;
      an_q   <= 2'b11;
      dig_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      an_q   <= an_d;
      dig_q  <= dig_d;
    end
  end

  // Slot timing and per-slot digit/anode selection; outputs lag the slot by one cycle.
  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    slot_d = slot_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      slot_d = ~slot_q;
    end
    if (!slot_q) begin
      an_d  = 2'b10;
      dig_d = disp_ones_q;
    end else begin
      dig_d = {2'b00, disp_tens_q};
      if (BLANK_LZ && (disp_tens_q == 2'd0)) an_d = 2'b11;
      else                                   an_d = 2'b01;
    end
  end

  assign add_a  = add_a_q;
  assign add_b  = add_b_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign done   = done_q;
  assign dig    = dig_q;
  assign an     = an_q;

endmodule

// File: tb/tb_add_disp_ctrl.sv
// Bench for add_disp_ctrl: two instances (slow scan with leading-zero blanking,
// fastest scan without blanking) share the operand inputs; each has its own
// behavioural 4-bit adder.
module tb_add_disp_ctrl;

  localparam int RD0 = 4;
  localparam bit BL0 = 1'b1;
  localparam int RD1 = 1;
  localparam bit BL1 = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0, b = '0;

  logic       in_ready0, ovf0, done0, add_cout0;
  logic [3:0] add_a0, add_b0, add_sum0, dig0;
  logic [4:0] result0;
  logic [1:0] an0;
  logic       in_ready1, ovf1, done1, add_cout1;
  logic [3:0] add_a1, add_b1, add_sum1, dig1;
  logic [4:0] result1;
  logic [1:0] an1;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  always #5 clk = ~clk;

  assign {add_cout0, add_sum0} = {1'b0, add_a0} + {1'b0, add_b0};
  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1};

  add_disp_ctrl #(.REFRESH_DIV(RD0), .BLANK_LZ(BL0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .add_a(add_a0), .add_b(add_b0), .add_sum(add_sum0),
    .add_cout(add_cout0), .result(result0), .ovf(ovf0), .done(done0),
    .dig(dig0), .an(an0));

  add_disp_ctrl #(.REFRESH_DIV(RD1), .BLANK_LZ(BL1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .add_a(add_a1), .add_b(add_b1), .add_sum(add_sum1),
    .add_cout(add_cout1), .result(result1), .ovf(ovf1), .done(done1),
    .dig(dig1), .an(an1));

  // Reference: after e clock edges since reset release, slot = floor((e-1)/rd) mod 2.
  function automatic logic [1:0] exp_an(int e, int rd, bit bl, int tens);
    if (((e - 1) / rd) % 2 == 0) return 2'b10;
    if (bl && tens == 0) return 2'b11;
    return 2'b01;
  endfunction

  function automatic logic [3:0] exp_dig(int e, int rd, int tens, int ones);
    if (((e - 1) / rd) % 2 == 0) return 4'(ones);
    return 4'(tens);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic check_disp(input int tens, input int ones);
    for (int i = 0; i < 2 * RD0 + 2; i++) begin
      checks++;
      if (an0 !== exp_an(edges, RD0, BL0, tens) || dig0 !== exp_dig(edges, RD0, tens, ones)) begin
        errors++;
        $display("FAIL scan0 e=%0d got an=%b dig=%0d exp an=%b dig=%0d", edges, an0, dig0,
                 exp_an(edges, RD0, BL0, tens), exp_dig(edges, RD0, tens, ones));
      end
      checks++;
      if (an1 !== exp_an(edges, RD1, BL1, tens) || dig1 !== exp_dig(edges, RD1, tens, ones)) begin
        errors++;
        $display("FAIL scan1 e=%0d got an=%b dig=%0d exp an=%b dig=%0d", edges, an1, dig1,
                 exp_an(edges, RD1, BL1, tens), exp_dig(edges, RD1, tens, ones));
      end
      step();
    end
  endtask

  task automatic run_op(input logic [3:0] av, input logic [3:0] bv);
    int r, cyc;
    r = int'(av) + int'(bv);
    checks++;
    if (in_ready0 !== 1'b1) begin
      errors++; $display("FAIL ready_before %0d+%0d got %b exp 1", av, bv, in_ready0);
    end
    in_valid = 1'b1; a = av; b = bv;
    step();
    in_valid = 1'b0; a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
    checks++;
    if (add_a0 !== av || add_b0 !== bv || in_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL operands %0d+%0d got add_a=%0d add_b=%0d ready=%b", av, bv, add_a0, add_b0, in_ready0);
    end
    cyc = 1;
    while (done0 !== 1'b1 && cyc < 20) begin
      step(); cyc++;
    end
    checks++;
    if (cyc != 3 + r / 10) begin
      errors++; $display("FAIL latency %0d+%0d got %0d exp %0d", av, bv, cyc, 3 + r / 10);
    end
    checks++;
    if (result0 !== 5'(r) || ovf0 !== (r > 15)) begin
      errors++; $display("FAIL result %0d+%0d got %0d ovf=%b exp %0d ovf=%b", av, bv, result0, ovf0, r, (r > 15));
    end
    checks++;
    if (in_ready0 !== 1'b1 || done1 !== done0 || result1 !== result0) begin
      errors++; $display("FAIL done_cycle %0d+%0d ready=%b done1=%b result1=%0d", av, bv, in_ready0, done1, result1);
    end
    step();
    checks++;
    if (done0 !== 1'b0) begin
      errors++; $display("FAIL done_pulse %0d+%0d got %b exp 0", av, bv, done0);
    end
    check_disp(r / 10, r % 10);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if (an0 !== 2'b11 || dig0 !== 4'd0 || in_ready0 !== 1'b1 || done0 !== 1'b0 ||
        result0 !== 5'd0 || ovf0 !== 1'b0 || add_a0 !== 4'd0 || add_b0 !== 4'd0 || an1 !== 2'b11) begin
      errors++;
      $display("FAIL reset_state got an=%b dig=%0d rdy=%b done=%b res=%0d ovf=%b an1=%b",
               an0, dig0, in_ready0, done0, result0, ovf0, an1);
    end
    rst_n = 1'b1;
    edges = 0;
    step();
    checks++;
    if (an0 !== 2'b10 || dig0 !== 4'd0 || an1 !== 2'b10 || dig1 !== 4'd0) begin
      errors++; $display("FAIL reset_release got an=%b dig=%0d an1=%b dig1=%0d exp 10/0", an0, dig0, an1, dig1);
    end
    check_disp(0, 0);
  endtask

  task automatic test_basic();
    run_op(4'd3, 4'd5);
    run_op(4'd12, 4'd10);
    run_op(4'd15, 4'd15);
  endtask

  task automatic test_busy();
    int cyc;
    in_valid = 1'b1; a = 4'd15; b = 4'd3;
    step();
    a = 4'd1; b = 4'd1;
    cyc = 1;
    while (done0 !== 1'b1 && cyc < 20) begin
      checks++;
      if (in_ready0 !== 1'b0 || add_a0 !== 4'd15 || add_b0 !== 4'd3) begin
        errors++; $display("FAIL busy_ignore got rdy=%b add_a=%0d add_b=%0d exp 0/15/3", in_ready0, add_a0, add_b0);
      end
      step(); cyc++;
    end
    checks++;
    if (cyc != 4 || result0 !== 5'd18) begin
      errors++; $display("FAIL busy_first got lat=%0d res=%0d exp 4/18", cyc, result0);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (add_a0 !== 4'd1 || add_b0 !== 4'd1) begin
      errors++; $display("FAIL busy_second_accept got %0d/%0d exp 1/1", add_a0, add_b0);
    end
    cyc = 1;
    while (done0 !== 1'b1 && cyc < 20) begin
      step(); cyc++;
    end
    checks++;
    if (cyc != 3 || result0 !== 5'd2 || ovf0 !== 1'b0) begin
      errors++; $display("FAIL busy_second got lat=%0d res=%0d ovf=%b exp 3/2/0", cyc, result0, ovf0);
    end
    step();
    check_disp(0, 2);
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; a = 4'd7; b = 4'd9;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (an0 !== 2'b11 || dig0 !== 4'd0 || in_ready0 !== 1'b1 || done0 !== 1'b0 ||
        result0 !== 5'd0 || ovf0 !== 1'b0 || add_a0 !== 4'd0 || add_b0 !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid got an=%b dig=%0d rdy=%b done=%b res=%0d add_a=%0d",
               an0, dig0, in_ready0, done0, result0, add_a0);
    end
    step(); step();
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (done0 !== 1'b0 || an0 !== exp_an(edges, RD0, BL0, 0) || dig0 !== 4'd0) begin
        errors++; $display("FAIL reset_mid_after e=%0d got done=%b an=%b dig=%0d", edges, done0, an0, dig0);
      end
    end
    run_op(4'd8, 4'd7);
  endtask

  task automatic test_scan_hold();
    int cyc;
    in_valid = 1'b1; a = 4'd12; b = 4'd10;
    step();
    in_valid = 1'b0;
    cyc = 1;
    while (1) begin
      checks++;
      if (an0 !== exp_an(edges, RD0, BL0, 1) || dig0 !== exp_dig(edges, RD0, 1, 5) ||
          an1 !== exp_an(edges, RD1, BL1, 1) || dig1 !== exp_dig(edges, RD1, 1, 5)) begin
        errors++; $display("FAIL hold_old e=%0d got an=%b dig=%0d an1=%b dig1=%0d", edges, an0, dig0, an1, dig1);
      end
      if (done0 === 1'b1 || cyc >= 20) break;
      step(); cyc++;
    end
    checks++;
    if (cyc != 5) begin
      errors++; $display("FAIL hold_latency got %0d exp 5", cyc);
    end
    step();
    check_disp(2, 2);
  endtask

  task automatic test_random();
    logic [3:0] av, bv;
    for (int n = 0; n < 24; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
      av = 4'($urandom_range(0, 15));
      bv = 4'($urandom_range(0, 15));
      run_op(av, bv);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_reset_mid();
    test_scan_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
